// File: rtl/pi_error_sequencer.sv
// Error/integral update sequencer driving a shared sign-magnitude adder over its
// enable/finish handshake; clamps the integral to +/-LIMIT and normalises -0.
module pi_error_sequencer #(
    parameter int WIDTH   = 16,
    parameter int LIMIT   = 1000,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] setpoint_i,
    input  logic [WIDTH-1:0] feedback_i,
    output logic             add_enable_o,
    output logic             add_summing_o,
    output logic [WIDTH-1:0] add_in1_o,
    output logic [WIDTH-1:0] add_in2_o,
    input  logic [WIDTH-1:0] add_result_i,
    input  logic             add_finish_i,
    output logic [WIDTH-1:0] error_o,
    output logic [WIDTH-1:0] integral_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             timeout_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH-2:0] LIM_MAG = (WIDTH-1)'(LIMIT);

    typedef enum logic [3:0] {
        S_IDLE, S_E_ISSUE, S_E_WLO, S_E_WHI,
        S_I_ISSUE, S_I_WLO, S_I_WHI, S_CLAMP, S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic             r_timeout;
    logic             r_summing;
    logic [WIDTH-1:0] r_add_in1;
    logic [WIDTH-1:0] r_add_in2;
    logic [WIDTH-1:0] r_integral;
    logic [WIDTH-1:0] r_err_raw;
    logic [WIDTH-1:0] r_int_raw;
    logic [WIDTH-1:0] r_error_o;
    logic [WIDTH-1:0] r_integral_o;

    logic             w_start;
    logic             w_clear;
    logic             w_cap_err;
    logic             w_cap_int;
    logic             w_abort;
    logic             w_wait;
    logic             w_tmo;
    logic [WIDTH-2:0] w_int_mag;
    logic [WIDTH-1:0] w_int_norm;
    logic [WIDTH-1:0] w_err_norm;

    assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_clear      = 1'b0;
        w_cap_err    = 1'b0;
        w_cap_int    = 1'b0;
        w_abort      = 1'b0;
        w_wait       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clear_i) begin
                    w_clear = 1'b1;
                end else if (start_i) begin
                    w_start      = 1'b1;
                    w_state_next = S_E_ISSUE;
                end
            end
            S_E_ISSUE: w_state_next = S_E_WLO;
            S_E_WLO, S_I_WLO: begin
                w_wait = 1'b1;
                if (!add_finish_i) begin
                    w_state_next = (r_state == S_E_WLO) ? S_E_WHI : S_I_WHI;
                end else if (w_tmo) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_E_WHI, S_I_WHI: begin
                w_wait = 1'b1;
                if (add_finish_i) begin
                    w_cap_err    = (r_state == S_E_WHI);
                    w_cap_int    = (r_state == S_I_WHI);
                    w_state_next = (r_state == S_E_WHI) ? S_I_ISSUE : S_CLAMP;
                end else if (w_tmo) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_I_ISSUE: w_state_next = S_I_WLO;
            S_CLAMP:   w_state_next = S_DONE;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Clamp magnitude first, then fold any zero magnitude to +0.
    assign w_int_mag  = (r_int_raw[WIDTH-2:0] > LIM_MAG) ? LIM_MAG : r_int_raw[WIDTH-2:0];
    assign w_int_norm = (w_int_mag == '0) ? '0 : {r_int_raw[WIDTH-1], w_int_mag};
    assign w_err_norm = (r_err_raw[WIDTH-2:0] == '0) ? '0 : r_err_raw;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt        <= '0;
            r_timeout    <= 1'b0;
            r_summing    <= 1'b0;
            r_add_in1    <= '0;
            r_add_in2    <= '0;
            r_integral   <= '0;
            r_err_raw    <= '0;
            r_int_raw    <= '0;
            r_error_o    <= '0;
            r_integral_o <= '0;
        end else begin
            // The counter restarts whenever a wait state is entered or left.
            if (w_wait && (w_state_next == r_state)) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (w_clear) begin
                r_integral <= '0;
            end
            if (w_start) begin
                r_add_in1 <= setpoint_i;
                r_add_in2 <= feedback_i;
                r_summing <= 1'b0;
                r_timeout <= 1'b0;
            end
            if (w_cap_err) begin
                r_err_raw <= add_result_i;
                r_add_in1 <= r_integral;
                r_add_in2 <= add_result_i;
                r_summing <= 1'b1;
            end
            if (w_cap_int) begin
                r_int_raw <= add_result_i;
            end
            if (r_state == S_CLAMP) begin
                r_integral   <= w_int_norm;
                r_integral_o <= w_int_norm;
                r_error_o    <= w_err_norm;
            end
            if (w_abort) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign add_enable_o  = (r_state == S_E_ISSUE) || (r_state == S_I_ISSUE);
    assign add_summing_o = r_summing;
    assign add_in1_o     = r_add_in1;
    assign add_in2_o     = r_add_in2;
    assign error_o       = r_error_o;
    assign integral_o    = r_integral_o;
    assign valid_o       = (r_state == S_DONE);
    assign busy_o        = (r_state != S_IDLE);
    assign timeout_o     = r_timeout;

endmodule
